// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM bench memory.
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } ram_state_t;

    localparam int WORD_BYTES = 4;

    // Expands a per-byte enable into a 32-bit bit mask (bit0 -> bits 7:0).
    function automatic logic [31:0] be_mask(input logic [WORD_BYTES-1:0] byteenable);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            mask[i*8 +: 8] = {8{byteenable[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_wait_ctr.sv
// Wait-state sequencer: counts WAIT_CYCLES stall cycles per bus access and
// reports completion, stall and master-abandoned-request events.
module ram_wait_ctr
    import mem_model_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic load_en_i,
    output logic done_o,
    output logic wait_o,
    output logic abort_o
);

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    ram_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        wait_o  = 1'b0;
        abort_o = 1'b0;

        if (load_en_i) begin
            wait_o = req_i;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (ZERO_WAIT) begin
                            done_o = 1'b1;
                        end else begin
                            wait_o  = 1'b1;
                            state_d = WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req_i) begin
                        abort_o = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_o = 1'b1;
                        if (cnt_q == 4'd0) state_d = DONE;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (req_i) done_o  = 1'b1;
                    else       abort_o = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs stay quiet while reset is held, even with a request pending.
        if (!reset) begin
            done_o  = 1'b0;
            wait_o  = 1'b0;
            abort_o = 1'b0;
        end
    end

endmodule

// File: rtl/avalon_ram_wait.sv
// Avalon-MM slave memory with programmable wait states, byte-lane writes,
// a clocked preload port and sticky error reporting.
module avalon_ram_wait
    import mem_model_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          LOAD_AW     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic [3:0]         byteenable,
    output logic               waitrequest,
    output logic [31:0]        readdata,
    input  logic               load_en,
    input  logic [LOAD_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    output logic               bus_error,
    output logic [31:0]        access_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             bus_error_q;
    logic [31:0]      count_q;

    logic             done;
    logic             abort;
    logic [31:0]      offset;
    logic             aligned;
    logic             in_range;
    logic             bad_access;
    logic [IDX_W-1:0] bus_idx;
    logic [31:0]      load_word;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      lane_mask;
    logic             unused_ok;

    ram_wait_ctr #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (read | write),
        .load_en_i(load_en),
        .done_o   (done),
        .wait_o   (waitrequest),
        .abort_o  (abort)
    );

    // BASE_ADDR is word-aligned, so the offset's low bits give the alignment.
    assign offset     = address - BASE_ADDR;
    assign aligned    = (offset[1:0] == 2'b00);
    assign in_range   = ((offset >> (IDX_W + 2)) == 32'd0);
    assign bus_idx    = offset[IDX_W+1:2];
    assign bad_access = ~aligned | ~in_range | (read & write);

    // Preload address wraps modulo DEPTH_WORDS by keeping only the low index bits.
    assign load_word = 32'(load_addr) >> 2;
    assign load_idx  = load_word[IDX_W-1:0];
    assign unused_ok = ^load_word[31:IDX_W];

    assign lane_mask = be_mask(byteenable);
    assign readdata  = (done && read && !bad_access) ? mem_q[bus_idx] : 32'd0;

    // NOTE: the array is cleared on reset so every run starts from all-zero memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            bus_error_q <= 1'b0;
            count_q     <= '0;
        end else begin
            if (load_en) begin
                mem_q[load_idx] <= load_data;
            end
            if (done && write && !bad_access) begin
                mem_q[bus_idx] <= (mem_q[bus_idx] & ~lane_mask) | (writedata & lane_mask);
            end
            if (done) begin
                count_q <= count_q + 32'd1;
            end
            if ((done && bad_access) || abort) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign bus_error    = bus_error_q;
    assign access_count = count_q;

endmodule

// File: tb/tb_avalon_ram_wait.sv
// Bench for avalon_ram_wait: a 2-wait-state instance and a zero-wait instance.
module tb_avalon_ram_wait;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] address = '0, writedata = '0, readdata, access_count, load_data = '0;
    logic        read = 1'b0, write = 1'b0, waitrequest, load_en = 1'b0, bus_error;
    logic [3:0]  byteenable = '0;
    logic [7:0]  load_addr = '0;

    logic [31:0] z_address = '0, z_writedata = '0, z_readdata, z_access_count, z_load_data = '0;
    logic        z_read = 1'b0, z_write = 1'b0, z_waitrequest, z_load_en = 1'b0, z_bus_error;
    logic [3:0]  z_byteenable = '0;
    logic [7:0]  z_load_addr = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count = 0;
    exp_t sb_q[$];
    vec_t vecs[19];

    always #5 clk = ~clk;

    avalon_ram_wait #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .LOAD_AW(8)) u_dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .bus_error(bus_error), .access_count(access_count)
    );

    avalon_ram_wait #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .LOAD_AW(8)) u_dut0 (
        .clk(clk), .reset(reset), .address(z_address), .read(z_read), .write(z_write),
        .writedata(z_writedata), .byteenable(z_byteenable), .waitrequest(z_waitrequest),
        .readdata(z_readdata), .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data),
        .bus_error(z_bus_error), .access_count(z_access_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Preload both instances with the same word; entered and left just after a rising edge.
    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1;  load_addr = a;  load_data = d;
        z_load_en = 1'b1; z_load_addr = a; z_load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        z_load_en = 1'b0;
    endtask

    // One access on the 2-wait instance; stall length and read data come off the scoreboard.
    task automatic access2(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] exp_rd, input string tag);
        exp_t e;
        int   lat;
        logic stall_data;
        e.rdata = exp_rd;
        e.lat   = 3;
        sb_q.push_back(e);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        lat = 0;
        stall_data = 1'b0;
        @(negedge clk);
        while (waitrequest && lat <= 40) begin
            if (readdata !== 32'd0) stall_data = 1'b1;
            lat++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check({tag, " stall cycles"}, 32'(lat), 32'(e.lat));
        check({tag, " readdata"}, readdata, e.rdata);
        check({tag, " readdata during stall"}, {31'd0, stall_data}, 32'd0);
        @(posedge clk); #1;
        read = 1'b0;
        write = 1'b0;
        exp_count++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b0101, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'b0000, 32'h00AD00EF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h10,  32'h11223344, 4'b1010, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'b0000, 32'h11AD33EF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h14,  32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h14,  32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h18,  32'h12345678, 4'b0000, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h18,  32'h0,        4'b0000, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h0A0B0C0D, 4'b1111, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'b0000, 32'h0A0B0C0D, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h08,  32'h0,        4'b0000, 32'h24030100, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h102, 32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h400, 32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'h14,  32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h14,  32'h0,        4'b0000, 32'hCAFEF00D, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h11,  32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'b0000, 32'h11AD33EF, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
        vecs[18] = '{1'b1, 1'b0, 32'h0,   32'h0,        4'b0000, 32'h0,        1'b1};

        // Reset held with requests pending: outputs must stay quiet.
        read = 1'b1; address = 32'h4; z_read = 1'b1; z_address = 32'h4;
        #12;
        check("reset waitrequest", {31'd0, waitrequest}, 32'd0);
        check("reset readdata", readdata, 32'd0);
        check("reset bus_error", {31'd0, bus_error}, 32'd0);
        check("reset access_count", access_count, 32'd0);
        check("reset z_waitrequest", {31'd0, z_waitrequest}, 32'd0);
        check("reset z_readdata", z_readdata, 32'd0);
        read = 1'b0; z_read = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        preload(8'h04, 32'h24020010);
        preload(8'h08, 32'h24030100);

        access2(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 32'h24020010, "t1 read 0x04");
        check("t1 access_count", access_count, 32'd1);

        for (int i = 0; i < 19; i++) begin
            access2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    vecs[i].exp_rdata, $sformatf("vec%0d", i));
            check($sformatf("vec%0d bus_error", i), {31'd0, bus_error}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d access_count", i), access_count, 32'(exp_count));
        end

        // Zero-wait instance: four back-to-back reads, each completing in its own cycle.
        begin
            logic [31:0] addrs [4];
            logic [31:0] datas [4];
            exp_t        e;
            addrs = '{32'h08, 32'h04, 32'h08, 32'h04};
            datas = '{32'h24030100, 32'h24020010, 32'h24030100, 32'h24020010};
            for (int i = 0; i < 4; i++) begin
                e.rdata = datas[i];
                e.lat   = 0;
                sb_q.push_back(e);
            end
            z_read = 1'b1;
            for (int i = 0; i < 4; i++) begin
                z_address = addrs[i];
                @(negedge clk);
                e = sb_q.pop_front();
                check($sformatf("t4 b2b%0d waitrequest", i), {31'd0, z_waitrequest}, 32'(e.lat));
                check($sformatf("t4 b2b%0d readdata", i), z_readdata, e.rdata);
                @(posedge clk); #1;
            end
            z_read = 1'b0;
            check("t4 access_count", z_access_count, 32'd4);
            z_write = 1'b1; z_address = 32'h20; z_writedata = 32'hAABBCCDD; z_byteenable = 4'b1100;
            @(negedge clk);
            check("t4 write waitrequest", {31'd0, z_waitrequest}, 32'd0);
            @(posedge clk); #1;
            z_write = 1'b0; z_read = 1'b1;
            @(negedge clk);
            check("t4 read-back", z_readdata, 32'hAABB0000);
            @(posedge clk); #1;
            z_read = 1'b0;
            check("t4 bus_error", {31'd0, z_bus_error}, 32'd0);
        end

        // Preload held over a bus read: stall lasts through load_en, then full latency.
        begin
            int held;
            int lat;
            held = 0;
            lat  = 0;
            load_en = 1'b1; load_addr = 8'h30; load_data = 32'h55AA55AA;
            read = 1'b1; address = 32'h30;
            repeat (4) begin
                @(negedge clk);
                if (waitrequest) held++;
            end
            @(posedge clk); #1;
            load_en = 1'b0;
            @(negedge clk);
            while (waitrequest && lat <= 40) begin
                lat++;
                @(negedge clk);
            end
            check("t5 stall during load_en", 32'(held), 32'd4);
            check("t5 stall after load_en", 32'(lat), 32'd3);
            check("t5 readdata", readdata, 32'h55AA55AA);
            @(posedge clk); #1;
            read = 1'b0;
            exp_count++;
            check("t5 access_count", access_count, 32'(exp_count));
        end

        // Reset in the middle of a write's wait phase.
        write = 1'b1; address = 32'h20; writedata = 32'h12345678; byteenable = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6 waitrequest at reset", {31'd0, waitrequest}, 32'd0);
        check("t6 access_count at reset", access_count, 32'd0);
        check("t6 bus_error at reset", {31'd0, bus_error}, 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        exp_count = 0;
        access2(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, "t6 read 0x20");
        check("t6 access_count", access_count, 32'd1);
        check("t6 bus_error", {31'd0, bus_error}, 32'd0);

        // Master abandons the request mid-wait.
        read = 1'b1; address = 32'h04;
        @(negedge clk);
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        check("abort bus_error", {31'd0, bus_error}, 32'd1);
        check("abort access_count", access_count, 32'd1);
        access2(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, "post-abort read");
        check("post-abort access_count", access_count, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
